// File: rtl/alu_pkg.sv
// Shared types for the ALU operation sequencer: opcode enum, response record
// and the opcode legality check.
package alu_pkg;

    localparam int unsigned ALU_SIZE  = 7;
    localparam int unsigned ALU_TAG_W = 4;
    localparam int unsigned ALU_DEPTH = 2;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01
    } alu_op_e;

    typedef struct packed {
        logic [ALU_SIZE:0]    result;
        logic [ALU_TAG_W-1:0] tag;
        logic                 err;
    } alu_rsp_t;

    function automatic logic is_legal_op(input logic [1:0] op);
        logic legal;
        case (op)
            ALU_ADD, ALU_SUB: legal = 1'b1;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// In-order response FIFO; accepts a push while full when a pop happens on the
// same edge, and presents an all-zero head when empty.
module alu_rsp_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH   = ALU_DEPTH,
    parameter type         entry_t = alu_rsp_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t pop_data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned     PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]  CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    entry_t           mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags and qualified push/pop strobes
    always_comb begin
        full_o     = (count_r == CNT_FULL);
        empty_o    = (count_r == {(PTR_W+1){1'b0}});
        do_pop_s   = pop_i && !empty_o;
        do_push_s  = push_i && (!full_o || do_pop_s);
        pop_data_o = empty_o ? '0 : mem_r[rd_ptr_r];
    end

    // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data_i;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues requests to an external combinational ALU from a single issue register
// and returns tagged results through a small response FIFO.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned SIZE  = ALU_SIZE,
    parameter int unsigned TAG_W = ALU_TAG_W,
    parameter int unsigned DEPTH = ALU_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [SIZE:0]    req_a_i,
    input  logic [SIZE:0]    req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic [1:0]       alu_operator_o,
    output logic [SIZE:0]    alu_operand_a_o,
    output logic [SIZE:0]    alu_operand_b_o,
    input  logic [SIZE:0]    alu_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [SIZE:0]    rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o,
    output logic [15:0]      op_count_o,
    output logic [7:0]       err_count_o
);

    typedef struct packed {
        logic [SIZE:0]    result;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;

    logic             s1_valid_r;
    logic [1:0]       s1_op_r;
    logic [SIZE:0]    s1_a_r;
    logic [SIZE:0]    s1_b_r;
    logic [TAG_W-1:0] s1_tag_r;
    logic [15:0]      op_count_r;
    logic [7:0]       err_count_r;

    logic pop_s;
    logic push_s;
    logic accept_s;
    logic fifo_full_s;
    logic fifo_empty_s;
    rsp_t push_data_s;
    rsp_t head_s;

    // Handshake: S1 drains into the FIFO whenever a slot is free or freed this edge
    always_comb begin
        pop_s       = !fifo_empty_s && rsp_ready_i;
        push_s      = s1_valid_r && (!fifo_full_s || pop_s);
        req_ready_o = !s1_valid_r || push_s;
        accept_s    = req_valid_i && req_ready_o;
    end

    // Response record; illegal opcodes discard whatever the ALU returned
    always_comb begin
        push_data_s.err    = !is_legal_op(s1_op_r);
        push_data_s.result = push_data_s.err ? {(SIZE+1){1'b0}} : alu_result_i;
        push_data_s.tag    = s1_tag_r;
    end

    // Issue register; operand fields keep their last values once S1 empties
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 2'b00;
            s1_a_r     <= {(SIZE+1){1'b0}};
            s1_b_r     <= {(SIZE+1){1'b0}};
            s1_tag_r   <= {TAG_W{1'b0}};
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_op_r    <= req_op_i;
            s1_a_r     <= req_a_i;
            s1_b_r     <= req_b_i;
            s1_tag_r   <= req_tag_i;
        end else if (push_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Push counters: total wraps, illegal-op count saturates
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_count_r  <= 16'h0000;
            err_count_r <= 8'h00;
        end else if (push_s) begin
            op_count_r <= op_count_r + 16'h0001;
            if (push_data_s.err && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'h01;
            end
        end
    end

    alu_rsp_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (rsp_t)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .pop_data_o  (head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    assign alu_operator_o  = s1_op_r;
    assign alu_operand_a_o = s1_a_r;
    assign alu_operand_b_o = s1_b_r;
    assign rsp_valid_o     = !fifo_empty_s;
    assign rsp_result_o    = head_s.result;
    assign rsp_tag_o       = head_s.tag;
    assign rsp_err_o       = head_s.err;
    assign op_count_o      = op_count_r;
    assign err_count_o     = err_count_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: requests push expected responses into
// a queue, a negedge monitor pops and compares every accepted response.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [1:0] req_op_i;
    logic [7:0] req_a_i;
    logic [7:0] req_b_i;
    logic [3:0] req_tag_i;
    logic [1:0] alu_operator_o;
    logic [7:0] alu_operand_a_o;
    logic [7:0] alu_operand_b_o;
    logic [7:0] alu_result_i;
    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic [7:0] rsp_result_o;
    logic [3:0] rsp_tag_o;
    logic       rsp_err_o;
    logic [15:0] op_count_o;
    logic [7:0] err_count_o;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_op_i        (req_op_i),
        .req_a_i         (req_a_i),
        .req_b_i         (req_b_i),
        .req_tag_i       (req_tag_i),
        .alu_operator_o  (alu_operator_o),
        .alu_operand_a_o (alu_operand_a_o),
        .alu_operand_b_o (alu_operand_b_o),
        .alu_result_i    (alu_result_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_result_o    (rsp_result_o),
        .rsp_tag_o       (rsp_tag_o),
        .rsp_err_o       (rsp_err_o),
        .op_count_o      (op_count_o),
        .err_count_o     (err_count_o)
    );

    // Stand-in ALU; garbage for illegal codes so the forced zero is observable
    assign alu_result_i = (alu_operator_o == 2'b00) ? alu_operand_a_o + alu_operand_b_o :
                          (alu_operator_o == 2'b01) ? alu_operand_a_o - alu_operand_b_o :
                                                      alu_operand_a_o ^ 8'hA5;

    typedef struct {
        logic [7:0] result;
        logic [3:0] tag;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_ops = 0;
    int   model_errs = 0;
    bit   rand_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input logic [3:0] tag);
        exp_t e;
        int   r;
        e.tag = tag;
        e.err = 1'b0;
        if (op == 2'd0) r = int'(a) + int'(b);
        else if (op == 2'd1) r = int'(a) - int'(b) + 256;
        else begin
            r = 0;
            e.err = 1'b1;
        end
        e.result = 8'(r % 256);
        return e;
    endfunction

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag, output int waits);
        exp_t e;
        req_valid_i = 1'b1;
        req_op_i = op;
        req_a_i = a;
        req_b_i = b;
        req_tag_i = tag;
        waits = 0;
        forever begin
            @(negedge clk);
            if (req_ready_o) break;
            waits++;
            if (waits > 200) break;
        end
        if (waits > 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: req_ready_o stuck at 0, tag %0h", tag);
        end else begin
            e = model(op, a, b, tag);
            sb_q.push_back(e);
            model_ops++;
            if (e.err) model_errs++;
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic drain_and_check_counters(input string name);
        int cyc = 0;
        rsp_ready_i = 1'b1;
        while (sb_q.size() > 0 && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d responses missing", name, sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_op_count"}, op_count_o, 32'(model_ops % 65536));
        chk({name, "_err_count"}, err_count_o, (model_errs > 255) ? 32'd255 : 32'(model_errs));
    endtask

    task automatic do_reset();
        req_valid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        sb_q.delete();
        model_ops = 0;
        model_errs = 0;
    endtask

    // Monitor: compares each transferred response and holds stalled ones stable
    initial begin
        exp_t e;
        bit   stalled = 1'b0;
        logic [12:0] held = 13'h0000;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                stalled = 1'b0;
            end else begin
                if (stalled) chk("rsp_stable", {rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o},
                                 {1'b1, held});
                if (!rsp_valid_o) chk("rsp_empty_zero", {rsp_result_o, rsp_tag_o, rsp_err_o}, 32'd0);
                if (rsp_valid_o && rsp_ready_i) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: tag %0h with empty scoreboard", rsp_tag_o);
                    end else begin
                        e = sb_q.pop_front();
                        chk("rsp_result", rsp_result_o, e.result);
                        chk("rsp_tag", rsp_tag_o, e.tag);
                        chk("rsp_err", rsp_err_o, e.err);
                    end
                    stalled = 1'b0;
                end else if (rsp_valid_o) begin
                    stalled = 1'b1;
                    held = {rsp_result_o, rsp_tag_o, rsp_err_o};
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    initial begin
        int w;
        int w4;
        logic [23:0] alu_snap;
        rst_i = 1'b1;
        req_valid_i = 1'b0;
        req_op_i = 2'b00;
        req_a_i = 8'h00;
        req_b_i = 8'h00;
        req_tag_i = 4'h0;
        rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset_state", {req_ready_o, rsp_valid_o, alu_operator_o, alu_operand_a_o,
                            alu_operand_b_o}, {1'b1, 1'b0, 18'h0});
        chk("reset_counters", {op_count_o, err_count_o}, 32'd0);
        @(posedge clk);
        #1;

        // Latency and basic ADD
        send(2'b00, 8'h05, 8'h03, 4'h1, w);
        @(negedge clk);
        chk("lat_n1_valid", rsp_valid_o, 32'd0);
        chk("lat_n1_alu", {alu_operator_o, alu_operand_a_o, alu_operand_b_o}, {2'b00, 8'h05, 8'h03});
        @(negedge clk);
        chk("lat_n2_valid", rsp_valid_o, 32'd1);
        @(posedge clk);
        #1;

        // Wrap-around results, then an illegal opcode
        send(2'b01, 8'h02, 8'h05, 4'h2, w);
        send(2'b00, 8'hFF, 8'h01, 4'h3, w);
        send(2'b11, 8'h10, 8'h01, 4'h4, w);
        drain_and_check_counters("basic");
        chk("illegal_err_count", err_count_o, 32'd1);

        // Backpressure: two in FIFO, one in S1, fourth request stalls
        rsp_ready_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) send(2'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 4'(5 + i), w);
                send(2'b01, 8'($urandom), 8'($urandom), 4'h8, w4);
            end
            begin
                repeat (5) @(negedge clk);
                chk("stall_req_ready", req_ready_o, 32'd0);
                chk("stall_rsp_valid", rsp_valid_o, 32'd1);
                alu_snap = {6'h00, alu_operator_o, alu_operand_a_o, alu_operand_b_o};
                repeat (3) @(negedge clk);
                chk("stall_alu_stable", {6'h00, alu_operator_o, alu_operand_a_o, alu_operand_b_o}, alu_snap);
                @(posedge clk);
                #1;
                rsp_ready_i = 1'b1;
            end
        join
        chk("stall_seen", w4 > 0, 32'd1);
        drain_and_check_counters("backpressure");

        // Full FIFO with consumer ready: one request per cycle
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send(2'b00, 8'($urandom), 8'($urandom), 4'(i), w);
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 4'(i + 3), w);
            chk("full_throughput", w, 32'd0);
        end
        drain_and_check_counters("throughput");

        // Reset with everything occupied
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send(2'b00, 8'($urandom), 8'($urandom), 4'(i + 9), w);
        do_reset();
        @(negedge clk);
        chk("midreset_rsp_valid", rsp_valid_o, 32'd0);
        chk("midreset_counters", {op_count_o, err_count_o}, 32'd0);
        chk("midreset_alu", {alu_operator_o, alu_operand_a_o, alu_operand_b_o}, 32'd0);
        chk("midreset_req_ready", req_ready_o, 32'd1);
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b1;
        send(2'b00, 8'h21, 8'h12, 4'hC, w);
        drain_and_check_counters("post_reset");

        // Random traffic with random consumer backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 4'($urandom), w);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain_and_check_counters("random");

        // Illegal-op counter saturation
        do_reset();
        for (int i = 0; i < 260; i++) send(2'($urandom_range(2, 3)), 8'($urandom), 8'($urandom), 4'(i), w);
        drain_and_check_counters("saturate");
        chk("saturate_err_ff", err_count_o, 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
